// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle datapath (master) and its controller (slave).
// All signals are level-valued every cycle; there is no valid/ready handshake on this bus.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic       exception;
    logic [3:0] state;

    modport master (
        output opcode, funct, zero, overflow,
        input  alu_control, alu_src_a, alu_src_b, pc_write, pc_write_cond,
        input  iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
        input  mem_to_reg, pc_source, exception, state
    );

    modport slave (
        input  opcode, funct, zero, overflow,
        output alu_control, alu_src_a, alu_src_b, pc_write, pc_write_cond,
        output iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
        output mem_to_reg, pc_source, exception, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM controller for a MIPS-style multicycle datapath.
// Optional feature: define OVERFLOW_TRAP_EN to trap on ADD/SUB/ADDI overflow.
module multicycle_control (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.slave   bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_LUI  = 4'b0101;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_BGEZ = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] rtype_alu;
    logic       exec_trap;
    logic       iexec_trap;

    // Branch resolution (pc_write_cond & zero) happens in the datapath.
    logic zero_unused;
    assign zero_unused = bus.zero;

    always_comb begin
        rtype_alu = ALU_ADD;
        case (bus.funct)
            FN_ADD:  rtype_alu = ALU_ADD;
            FN_SUB:  rtype_alu = ALU_SUB;
            FN_AND:  rtype_alu = ALU_AND;
            FN_OR:   rtype_alu = ALU_OR;
            FN_SLT:  rtype_alu = ALU_SLT;
            FN_NOR:  rtype_alu = ALU_NOR;
            default: rtype_alu = ALU_ADD;
        endcase
    end

`ifdef OVERFLOW_TRAP_EN
    // Only arithmetic that can overflow in the signed sense is trapped.
    assign exec_trap  = bus.overflow && ((rtype_alu == ALU_ADD) || (rtype_alu == ALU_SUB));
    assign iexec_trap = bus.overflow && (bus.opcode == OP_ADDI);
`else
    logic overflow_unused;
    assign overflow_unused = bus.overflow;
    assign exec_trap       = 1'b0;
    assign iexec_trap      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        bus.alu_control   = ALU_ADD;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.pc_source     = 2'd0;
        bus.exception     = 1'b0;

        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.pc_write  = 1'b1;
                state_d       = DECODE;
            end
            DECODE: begin
                // Branch target is computed speculatively while the opcode is decoded.
                bus.alu_src_b = 2'd3;
                case (bus.opcode)
                    OP_LW, OP_SW:            state_d = MEMADR;
                    OP_RTYPE:                state_d = EXEC;
                    OP_BEQ, OP_BNE, OP_BGEZ: state_d = BRANCH;
                    OP_ADDI, OP_LUI:         state_d = IEXEC;
                    OP_J:                    state_d = JUMP;
                    default:                 state_d = FETCH;
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                state_d       = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                state_d      = MEMWB;
            end
            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = FETCH;
            end
            MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                state_d       = FETCH;
            end
            EXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = rtype_alu;
                state_d         = exec_trap ? TRAP : RWB;
            end
            RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'd1;
                case (bus.opcode)
                    OP_BNE:  bus.alu_control = ALU_BNE;
                    OP_BGEZ: bus.alu_control = ALU_BGEZ;
                    default: bus.alu_control = ALU_SUB;
                endcase
                state_d = FETCH;
            end
            IEXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'd2;
                bus.alu_control = (bus.opcode == OP_LUI) ? ALU_LUI : ALU_ADD;
                state_d         = iexec_trap ? TRAP : IWB;
            end
            IWB: begin
                bus.reg_write = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'd2;
                state_d       = FETCH;
            end
            TRAP: begin
                bus.exception = 1'b1;
                state_d       = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these ports, clock and reset first; all outputs are Moore-decoded from the current state.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- opcode  in  6  instruction register bits [31:26].
- funct  in  6  instruction register bits [5:0].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU overflow flag.
- alu_control  out  4  ALU operation code.
- alu_src_a  out  1  0=PC, 1=register A.
- alu_src_b  out  2  0=register B, 1=constant 4, 2=sign-extended immediate, 3=sign-extended immediate shifted left 2.
- pc_write, pc_write_cond  out  1 each  unconditional and zero-qualified PC load.
- iord, mem_read, mem_write, ir_write  out  1 each  memory address select and strobes.
- reg_write, reg_dst, mem_to_reg  out  1 each  register file controls.
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target.
- exception  out  1  trap indication.
- state  out  4  current state, for debug.

Function
REQ-002 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, TRAP=12.
REQ-003 ALU codes SHALL be: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100, LUI=0101, BNE=1010, BGEZ=1111.
REQ-004 FETCH SHALL drive mem_read=1, ir_write=1, iord=0, alu_src_a=0, alu_src_b=1, ADD, pc_write=1, pc_source=0, then go to DECODE.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=3, ADD, and branch on opcode:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100, 000101 or 000001 -> BRANCH
- 001000 or 001111 -> IEXEC
- 000010 -> JUMP
- any other opcode -> FETCH, with no architectural side effect.
REQ-006 MEMADR SHALL drive alu_src_a=1, alu_src_b=2, ADD, then go to MEMRD for lw or MEMWR for sw.
REQ-007 MEMRD SHALL drive mem_read=1, iord=1, then go to MEMWB; MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-008 MEMWR SHALL drive mem_write=1, iord=1, then go to FETCH.
REQ-009 EXEC SHALL drive alu_src_a=1, alu_src_b=0 and map funct to the ALU code: 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 101010->SLT, 100111->NOR, any other->ADD. It SHALL then go to RWB.
REQ-010 RWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-011 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, pc_write_cond=1, pc_source=1, then go to FETCH. ALU code is SUB for 000100, BNE for 000101, BGEZ for 000001; the branch is taken when zero=1 in all three cases.
REQ-012 IEXEC SHALL drive alu_src_a=1, alu_src_b=2, with ADD for 001000 or LUI for 001111, then go to IWB; IWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-013 JUMP SHALL drive pc_write=1, pc_source=2, then go to FETCH.
REQ-014 Cycle counts SHALL be: lw 5, R-type/addi/lui/sw 4, branch/jump 3.
REQ-015 Every strobe not listed for a state SHALL be 0 in that state; alu_control SHALL be ADD by default.

Reset
REQ-016 rst_n=0 SHALL immediately force state=FETCH and exception=0, including mid-instruction; FETCH outputs then appear combinationally.
REQ-017 The first rising edge of clk after rst_n deasserts SHALL complete FETCH.

Configuration
REQ-018 OVERFLOW_TRAP_EN defined: overflow=1 sampled in EXEC (ADD/SUB) or IEXEC (ADD) SHALL go to TRAP instead of RWB/IWB. TRAP drives exception=1 with all writes 0, holds for 1 cycle, then goes to FETCH. OVERFLOW_TRAP_EN undefined: overflow is ignored and the TRAP state is unreachable.

Verification
REQ-019 Reset mid-MEMRD (rst_n low) -> state=0 asynchronously; next edge after release -> state=1.
REQ-020 opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4, mem_to_reg=1.
REQ-021 opcode=000000, funct=101010 -> alu_control=0111 in EXEC; reg_dst=1 in RWB; 4 cycles total.
REQ-022 opcode=000101: zero=1 -> pc_write_cond=1, alu_control=1010 in BRANCH. opcode=000001 -> alu_control=1111.
REQ-023 opcode=001000 with overflow=1 in IEXEC: OVERFLOW_TRAP_EN defined -> states 9,12,0 with exception=1, reg_write=0; undefined -> states 9,10 with reg_write=1.
REQ-024 opcode=111111 -> states 0,1,0 with no write strobes asserted.
